wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 81 ++++++++
 tb/tb_wb_regfile.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back register file: x86 partial-width merge on retirement, a busy
// scoreboard for pending destinations, and read ports that see this cycle's writes.
module wb_regfile #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 16,
  parameter int NWR    = 2,
  parameter int NRD    = 2,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NWR-1:0]                 wb_valid,
  input  logic [NWR-1:0][ADDR_W-1:0]     wb_reg,
  input  logic [NWR-1:0][1:0]            wb_size,
  input  logic [NWR-1:0][DATA_W-1:0]     wb_data,
  input  logic                           rsv_valid,
  input  logic [ADDR_W-1:0]              rsv_reg,
  output logic                           rsv_ready,
  input  logic [NRD-1:0][ADDR_W-1:0]     rd_reg,
  output logic [NRD-1:0][DATA_W-1:0]     rd_data,
  output logic [NRD-1:0]                 rd_busy
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;

  logic [DATA_W-1:0] nxt [NREGS];
  logic [NREGS-1:0]  wr_hit;

  // 8/16-bit writes keep the upper bits; a 32-bit write zero-extends.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_val,
                                              input logic [DATA_W-1:0] data,
                                              input logic [1:0]        size);
    case (size)
      2'd0:    merge = {old_val[DATA_W-1:8], data[7:0]};
      2'd1:    merge = {old_val[DATA_W-1:16], data[15:0]};
      2'd2:    merge = {{(DATA_W-32){1'b0}}, data[31:0]};
      default: merge = data;
    endcase
  endfunction

  // Ports are folded in ascending order so the highest port is youngest.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      nxt[r] = regs[r];
      for (int p = 0; p < NWR; p++) begin
        if (wb_valid[p] && (wb_reg[p] == ADDR_W'(r))) begin
          nxt[r]    = merge(nxt[r], wb_data[p], wb_size[p]);
          wr_hit[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data[i] = nxt[rd_reg[i]];
      rd_busy[i] = busy[rd_reg[i]] & ~wr_hit[rd_reg[i]];
    end
  end

  assign rsv_ready = rsv_valid & ~reset & (~busy[rsv_reg] | wr_hit[rsv_reg]);

  // A reservation accepted alongside a write to the same register wins on busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs[r] <= nxt[r];
      for (int r = 0; r < NREGS; r++) begin
        if (rsv_ready && (rsv_reg == ADDR_W'(r)))
          busy[r] <= 1'b1;
        else if (wr_hit[r])
          busy[r] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a per-cycle vector table plus hand-written
// reset sequences.
module tb_wb_regfile;

  localparam int AW = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [1:0]              wb_valid;
  logic [1:0][AW-1:0]      wb_reg;
  logic [1:0][1:0]         wb_size;
  logic [1:0][63:0]        wb_data;
  logic                    rsv_valid;
  logic [AW-1:0]           rsv_reg;
  logic                    rsv_ready;
  logic [1:0][AW-1:0]      rd_reg;
  logic [1:0][63:0]        rd_data;
  logic [1:0]              rd_busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [3:0] RAX = 4'd0, RCX = 4'd1, RDX = 4'd2, RBX = 4'd3,
                         R8 = 4'd8, R15 = 4'd15;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_size(wb_size), .wb_data(wb_data),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .rsv_ready(rsv_ready),
    .rd_reg(rd_reg), .rd_data(rd_data), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] wv;
    logic [3:0] wr0, wr1;
    logic [1:0] ws0, ws1;
    logic [63:0] wd0, wd1;
    logic       rv;
    logic [3:0] rr;
    logic [3:0] a0, a1;
    logic       e_rdy;
    logic [63:0] e_d0, e_d1;
    logic       e_b0, e_b1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [1:0] wv,
                              logic [3:0] wr0, logic [1:0] ws0, logic [63:0] wd0,
                              logic [3:0] wr1, logic [1:0] ws1, logic [63:0] wd1,
                              logic rv, logic [3:0] rr, logic [3:0] a0, logic [3:0] a1,
                              logic e_rdy, logic [63:0] e_d0, logic e_b0,
                              logic [63:0] e_d1, logic e_b1);
    vec_t v;
    v.name = name; v.wv = wv;
    v.wr0 = wr0; v.ws0 = ws0; v.wd0 = wd0;
    v.wr1 = wr1; v.ws1 = ws1; v.wd1 = wd1;
    v.rv = rv; v.rr = rr; v.a0 = a0; v.a1 = a1;
    v.e_rdy = e_rdy; v.e_d0 = e_d0; v.e_b0 = e_b0; v.e_d1 = e_d1; v.e_b1 = e_b1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    wb_valid   = v.wv;
    wb_reg[0]  = v.wr0; wb_size[0] = v.ws0; wb_data[0] = v.wd0;
    wb_reg[1]  = v.wr1; wb_size[1] = v.ws1; wb_data[1] = v.wd1;
    rsv_valid  = v.rv;  rsv_reg    = v.rr;
    rd_reg[0]  = v.a0;  rd_reg[1]  = v.a1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wb_valid = '0; wb_reg = '0; wb_size = '0; wb_data = '0;
    rsv_valid = 1'b0; rsv_reg = '0; rd_reg = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    vecs.push_back(mk("rax_w64", 2'b01, RAX, 2'd3, 64'h1122334455667788, RAX, 2'd0, 64'h0,
                      1'b0, RAX, RAX, RCX, 1'b0, 64'h1122334455667788, 1'b0, 64'h0, 1'b0));
    vecs.push_back(mk("rax_w8", 2'b01, RAX, 2'd0, 64'hABCDEF00000000FF, RAX, 2'd0, 64'h0,
                      1'b0, RAX, RAX, RCX, 1'b0, 64'h11223344556677FF, 1'b0, 64'h0, 1'b0));
    vecs.push_back(mk("rax_w16_p1", 2'b10, RAX, 2'd0, 64'h0, RAX, 2'd1, 64'h0000_5555_0000_AAAA,
                      1'b0, RAX, RAX, RCX, 1'b0, 64'h112233445566AAAA, 1'b0, 64'h0, 1'b0));
    vecs.push_back(mk("rax_w32", 2'b01, RAX, 2'd2, 64'hFFFFFFFFDEADBEEF, RAX, 2'd0, 64'h0,
                      1'b0, RAX, RAX, RCX, 1'b0, 64'h00000000DEADBEEF, 1'b0, 64'h0, 1'b0));
    vecs.push_back(mk("rax_hold", 2'b00, RAX, 2'd0, 64'h0, RAX, 2'd0, 64'h0,
                      1'b0, RAX, RAX, RCX, 1'b0, 64'h00000000DEADBEEF, 1'b0, 64'h0, 1'b0));
    vecs.push_back(mk("rcx_merge", 2'b11, RCX, 2'd3, 64'hFFFFFFFFFFFFFFFF, RCX, 2'd0, 64'h12,
                      1'b0, RAX, RCX, RAX, 1'b0, 64'hFFFFFFFFFFFFFF12, 1'b0, 64'h00000000DEADBEEF, 1'b0));
    vecs.push_back(mk("rcx_hold", 2'b00, RAX, 2'd0, 64'h0, RAX, 2'd0, 64'h0,
                      1'b0, RAX, RCX, RAX, 1'b0, 64'hFFFFFFFFFFFFFF12, 1'b0, 64'h00000000DEADBEEF, 1'b0));
    vecs.push_back(mk("rcx_order", 2'b11, RCX, 2'd0, 64'h77, RCX, 2'd2, 64'h89ABCDEF,
                      1'b0, RAX, RCX, RAX, 1'b0, 64'h0000000089ABCDEF, 1'b0, 64'h00000000DEADBEEF, 1'b0));
    vecs.push_back(mk("rdx_rsv", 2'b00, RAX, 2'd0, 64'h0, RAX, 2'd0, 64'h0,
                      1'b1, RDX, RDX, RCX, 1'b1, 64'h0, 1'b0, 64'h0000000089ABCDEF, 1'b0));
    vecs.push_back(mk("rdx_rsv_again", 2'b00, RAX, 2'd0, 64'h0, RAX, 2'd0, 64'h0,
                      1'b1, RDX, RDX, RCX, 1'b0, 64'h0, 1'b1, 64'h0000000089ABCDEF, 1'b0));
    vecs.push_back(mk("rdx_wr_rsv", 2'b01, RDX, 2'd3, 64'h5, RAX, 2'd0, 64'h0,
                      1'b1, RDX, RDX, RCX, 1'b1, 64'h5, 1'b0, 64'h0000000089ABCDEF, 1'b0));
    vecs.push_back(mk("rdx_busy_again", 2'b00, RAX, 2'd0, 64'h0, RAX, 2'd0, 64'h0,
                      1'b0, RDX, RDX, RBX, 1'b0, 64'h5, 1'b1, 64'h0, 1'b0));
    vecs.push_back(mk("rbx_rsv", 2'b00, RAX, 2'd0, 64'h0, RAX, 2'd0, 64'h0,
                      1'b1, RBX, RBX, RDX, 1'b1, 64'h0, 1'b0, 64'h5, 1'b1));
    vecs.push_back(mk("rbx_wr", 2'b10, RAX, 2'd0, 64'h0, RBX, 2'd3, 64'h7,
                      1'b0, RBX, RBX, RDX, 1'b0, 64'h7, 1'b0, 64'h5, 1'b1));
    vecs.push_back(mk("rbx_after", 2'b00, RAX, 2'd0, 64'h0, RAX, 2'd0, 64'h0,
                      1'b1, RDX, RBX, RDX, 1'b0, 64'h7, 1'b0, 64'h5, 1'b1));
    vecs.push_back(mk("split_ports", 2'b11, RAX, 2'd0, 64'h01, RBX, 2'd1, 64'hFFFF1234,
                      1'b0, RAX, RAX, RBX, 1'b0, 64'h00000000DEADBE01, 1'b0, 64'h1234, 1'b0));
    vecs.push_back(mk("unbusy_write", 2'b01, R8, 2'd3, 64'hCAFE, RAX, 2'd0, 64'h0,
                      1'b0, RAX, R8, RBX, 1'b0, 64'hCAFE, 1'b0, 64'h1234, 1'b0));

    // Reset must clear every register and busy bit.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int r = 0; r < 16; r += 2) begin
      rd_reg[0] = AW'(r); rd_reg[1] = AW'(r + 1);
      @(negedge clk);
      checkOutput($sformatf("reset_d%0d", r),     rd_data[0], 64'h0);
      checkOutput($sformatf("reset_d%0d", r + 1), rd_data[1], 64'h0);
      checkOutput($sformatf("reset_b%0d", r),     {63'h0, rd_busy[0]}, 64'h0);
      checkOutput($sformatf("reset_b%0d", r + 1), {63'h0, rd_busy[1]}, 64'h0);
    end

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput({vecs[i].name, "_rdy"}, {63'h0, rsv_ready}, {63'h0, vecs[i].e_rdy});
      checkOutput({vecs[i].name, "_d0"},  rd_data[0], vecs[i].e_d0);
      checkOutput({vecs[i].name, "_b0"},  {63'h0, rd_busy[0]}, {63'h0, vecs[i].e_b0});
      checkOutput({vecs[i].name, "_d1"},  rd_data[1], vecs[i].e_d1);
      checkOutput({vecs[i].name, "_b1"},  {63'h0, rd_busy[1]}, {63'h0, vecs[i].e_b1});
    end

    // Reserve R15 and write R8, then reset alongside another R8 write.
    @(posedge clk); #1;
    idle();
    wb_valid = 2'b01; wb_reg[0] = R8; wb_size[0] = 2'd3; wb_data[0] = 64'h42;
    rsv_valid = 1'b1; rsv_reg = R15;
    rd_reg[0] = R8; rd_reg[1] = R15;
    @(negedge clk);
    checkOutput("pre_reset_rdy", {63'h0, rsv_ready}, 64'h1);
    checkOutput("pre_reset_r8",  rd_data[0], 64'h42);
    @(posedge clk); #1;
    idle();
    rd_reg[0] = R8; rd_reg[1] = R15;
    @(negedge clk);
    checkOutput("r15_busy_set", {63'h0, rd_busy[1]}, 64'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    wb_valid = 2'b01; wb_reg[0] = R8; wb_size[0] = 2'd3; wb_data[0] = 64'h99;
    rsv_valid = 1'b1; rsv_reg = RAX;
    @(negedge clk);
    checkOutput("rdy_in_reset", {63'h0, rsv_ready}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    rd_reg[0] = R8; rd_reg[1] = R15;
    @(negedge clk);
    checkOutput("post_reset_r8",       rd_data[0], 64'h0);
    checkOutput("post_reset_r15_busy", {63'h0, rd_busy[1]}, 64'h0);
    rsv_valid = 1'b1; rsv_reg = R15;
    #1;
    checkOutput("post_reset_rsv_r15", {63'h0, rsv_ready}, 64'h1);
    @(posedge clk); #1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
